// File: rtl/pcm_to_dbl_if.sv
// PCM sample in / IEEE-754 double out bundle between the sample source and the HPF front end.
// Latency: none, wires only.
// Backpressure: pcm_ready paces the input side; the output side is a bare ce strobe with no stall.
interface pcm_to_dbl_if;
    logic [15:0] pcm_in;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [63:0] data;
    logic        ce;
    logic        sof;
    logic [6:0]  sample_idx;

    // The converter block itself.
    modport slave (
        input  pcm_in,
        input  pcm_valid,
        output pcm_ready,
        output data,
        output ce,
        output sof,
        output sample_idx
    );

    // The PCM producer that also observes the converted stream.
    modport master (
        output pcm_in,
        output pcm_valid,
        input  pcm_ready,
        input  data,
        input  ce,
        input  sof,
        input  sample_idx
    );
endinterface

// File: rtl/pcm_to_dbl.sv
// Converts signed 16-bit PCM to exact IEEE-754 doubles with 80-sample frame markers.
// Latency: sample accepted at edge N gives ce in the cycle after edge N+2.
// Backpressure: input paced only by MIN_GAP idle cycles; the output never stalls.
module pcm_to_dbl #(
    parameter int FRAME_LEN = 80,
    parameter int MIN_GAP   = 0
) (
    input  logic         clk,
    input  logic         rst,
    pcm_to_dbl_if.slave  bus
);

    localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);

    // Pacing
    logic [GW-1:0] gap_q, gap_d;
    logic          accept;

    // Stage 1: sign / magnitude
    logic          s1_vld_q;
    logic          s1_sign_q, s1_sign_d;
    logic [16:0]   s1_mag_q, s1_mag_d;

    // Stage 2: exponent / mantissa
    logic          s2_vld_q;
    logic          s2_sign_q;
    logic          s2_zero_q, s2_zero_d;
    logic [10:0]   s2_exp_q, s2_exp_d;
    logic [51:0]   s2_mant_q, s2_mant_d;
    logic [3:0]    lead_p;

    // Output stage
    logic [63:0]   data_q, data_d;
    logic          ce_q;
    logic [6:0]    idx_q, idx_d;

    assign bus.pcm_ready = !rst && (gap_q == '0);
    assign accept        = bus.pcm_valid && bus.pcm_ready;

    // Gap counter reloads on every accept and then drains to zero, reopening ready.
    always_comb begin
        gap_d = gap_q;
        if (accept) begin
            gap_d = GW'(MIN_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end
    end

    // Split the sample into sign and magnitude; -32768 becomes 32768 without saturation.
    always_comb begin
        s1_sign_d = bus.pcm_in[15];
        if (bus.pcm_in[15]) begin
            s1_mag_d = 17'd0 - {1'b1, bus.pcm_in};
        end else begin
            s1_mag_d = {1'b0, bus.pcm_in};
        end
    end

    // Leading-one position sets the exponent; bits below it form the left-justified mantissa.
    always_comb begin
        lead_p = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (s1_mag_q[i]) begin
                lead_p = 4'(i);
            end
        end
        s2_zero_d = (s1_mag_q == 17'd0);
        s2_exp_d  = 11'd1023 + {7'd0, lead_p};
        // Shifting by 16-p pushes the implicit leading one out past bit 51.
        s2_mant_d = {s1_mag_q[15:0], 36'd0} << (5'd16 - {1'b0, lead_p});
    end

    // Assemble the double; a zero magnitude always yields +0 regardless of sign.
    always_comb begin
        data_d = data_q;
        if (s2_vld_q) begin
            if (s2_zero_q) begin
                data_d = 64'h0;
            end else begin
                data_d = {s2_sign_q, s2_exp_q, s2_mant_q};
            end
        end
    end

    // Frame index advances after each strobe so it names the sample currently on data.
    always_comb begin
        idx_d = idx_q;
        if (ce_q) begin
            if (idx_q == 7'(FRAME_LEN - 1)) begin
                idx_d = 7'd0;
            end else begin
                idx_d = idx_q + 7'd1;
            end
        end
    end

    // Pipeline, pacing and framing state; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_mant_q <= '0;
            data_q    <= '0;
            ce_q      <= 1'b0;
            idx_q     <= '0;
        end else begin
            gap_q     <= gap_d;
            s1_vld_q  <= accept;
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s2_vld_q  <= s1_vld_q;
            s2_sign_q <= s1_sign_q;
            s2_zero_q <= s2_zero_d;
            s2_exp_q  <= s2_exp_d;
            s2_mant_q <= s2_mant_d;
            data_q    <= data_d;
            ce_q      <= s2_vld_q;
            idx_q     <= idx_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.ce         = ce_q;
    assign bus.sof        = ce_q && (idx_q == 7'd0);
    assign bus.sample_idx = idx_q;

endmodule
